// File: rtl/spi_master_24_if.sv
// spi_master_24_if
//   Command/handshake bundle between the process controller and one
//   spi_master_24 engine. Signal prefixes are from the engine's side.
//   i_start       command strobe, honoured only while o_ready=1
//   i_dir         0 = write only, 1 = write + read
//   i_data_tx     word to shift out (low i_data_depth bits used)
//   i_data_depth  bits per transaction
//   o_ready       engine idle and able to accept i_start
//   o_done        one-cycle pulse at transaction end
//   o_data_rx     captured read word, right-aligned
interface spi_master_24_if #(
    parameter int DATA_WIDTH = 24
) ();
    logic                  i_start;
    logic                  i_dir;
    logic [DATA_WIDTH-1:0] i_data_tx;
    logic [7:0]            i_data_depth;
    logic                  o_ready;
    logic                  o_done;
    logic [DATA_WIDTH-1:0] o_data_rx;

    // Controller side
    modport master (
        output i_start, i_dir, i_data_tx, i_data_depth,
        input  o_ready, o_done, o_data_rx
    );

    // Engine side
    modport slave (
        input  i_start, i_dir, i_data_tx, i_data_depth,
        output o_ready, o_done, o_data_rx
    );
endinterface

// File: rtl/spi_master_24.sv
// spi_master_24
//   Single-channel SPI write/read engine, mode 0, MSB first, with a
//   chip-select (LE) deassert gap after every word.
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   bus          command/handshake bundle (slave modport)
//   i_spi_miso   serial data from the device
//   o_spi_sclk   serial clock, idles low
//   o_spi_mosi   serial data to the device
//   o_spi_cs_n   chip select / LE, active low
//   Every phase (LOW, HIGH, HOLD, GAP) lasts CLK_DIV system clocks. All
//   outputs are registered copies of state-decoded values, so pins lag the
//   state register by one cycle.
module spi_master_24 #(
    parameter int CLK_DIV    = 4,
    parameter int DATA_WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    spi_master_24_if.slave   bus,
    input  logic             i_spi_miso,
    output logic             o_spi_sclk,
    output logic             o_spi_mosi,
    output logic             o_spi_cs_n
);
    localparam int         DIVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [7:0] DW8  = 8'(DATA_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_HOLD,
        S_GAP
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [DIVW-1:0]       r_div;
    logic [DATA_WIDTH-1:0] r_sh;
    logic [DATA_WIDTH-1:0] r_rx;
    logic [7:0]            r_bits;
    logic                  r_dir;
    logic                  r_last_gap;

    logic                  r_ready;
    logic                  r_done;
    logic [DATA_WIDTH-1:0] r_data_rx;
    logic                  r_sclk;
    logic                  r_mosi;
    logic                  r_cs_n;

    logic                  w_div_last;
    logic [7:0]            w_depth_n;
    logic [DATA_WIDTH-1:0] w_tx_aligned;
    logic                  w_accept;

    logic                  w_ready;
    logic                  w_done;
    logic                  w_sclk;
    logic                  w_mosi;
    logic                  w_cs_n;
    logic                  w_rx_load;

    assign w_div_last   = (r_div == DIVW'(CLK_DIV - 1));
    assign w_depth_n    = (bus.i_data_depth > DW8) ? DW8 : bus.i_data_depth;
    assign w_tx_aligned = bus.i_data_tx << (DW8 - w_depth_n);
    // r_ready is only checked together with IDLE: it stays high for one
    // cycle after acceptance because it is a registered copy of the state.
    assign w_accept     = (r_state == S_IDLE) && r_ready && bus.i_start &&
                          (bus.i_data_depth != 8'd0);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE: if (w_accept)   w_state_next = S_LOW;
            S_LOW:  if (w_div_last) w_state_next = S_HIGH;
            S_HIGH: if (w_div_last) w_state_next = (r_bits > 8'd1) ? S_LOW : S_HOLD;
            S_HOLD: if (w_div_last) w_state_next = S_GAP;
            S_GAP:  if (w_div_last) w_state_next = S_IDLE;
            default:                w_state_next = S_IDLE;
        endcase
    end

    // Output decode; registered below
    always_comb begin
        w_ready   = (r_state == S_IDLE);
        // First cycle of IDLE after GAP
        w_done    = (r_state == S_IDLE) && r_last_gap;
        w_cs_n    = (r_state == S_IDLE) || (r_state == S_GAP);
        w_sclk    = (r_state == S_HIGH);
        w_mosi    = 1'b0;
        if ((r_state == S_LOW) || (r_state == S_HIGH) || (r_state == S_HOLD)) begin
            w_mosi = r_sh[DATA_WIDTH-1];
        end
        w_rx_load = w_done && r_dir;
    end

    // Phase divider, shift registers and transaction context
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div      <= '0;
            r_sh       <= '0;
            r_rx       <= '0;
            r_bits     <= '0;
            r_dir      <= 1'b0;
            r_last_gap <= 1'b0;
        end else begin
            r_last_gap <= (r_state == S_GAP);

            if ((r_state == S_IDLE) || w_div_last) begin
                r_div <= '0;
            end else begin
                r_div <= r_div + 1'b1;
            end

            if (w_accept) begin
                r_sh   <= w_tx_aligned;
                r_rx   <= '0;
                r_bits <= w_depth_n;
                r_dir  <= bus.i_dir;
            end

            // MISO is taken as LOW ends; the device has had the whole low
            // phase to settle the bit.
            if ((r_state == S_LOW) && w_div_last) begin
                r_rx <= {r_rx[DATA_WIDTH-2:0], i_spi_miso};
            end

            if ((r_state == S_HIGH) && w_div_last && (r_bits > 8'd1)) begin
                r_sh   <= r_sh << 1;
                r_bits <= r_bits - 8'd1;
            end
        end
    end

    // Output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ready   <= 1'b0;
            r_done    <= 1'b0;
            r_data_rx <= '0;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b0;
            r_cs_n    <= 1'b1;
        end else begin
            r_ready <= w_ready;
            r_done  <= w_done;
            r_sclk  <= w_sclk;
            r_mosi  <= w_mosi;
            r_cs_n  <= w_cs_n;
            if (w_rx_load) begin
                r_data_rx <= r_rx;
            end
        end
    end

    assign bus.o_ready   = r_ready;
    assign bus.o_done    = r_done;
    assign bus.o_data_rx = r_data_rx;
    assign o_spi_sclk    = r_sclk;
    assign o_spi_mosi    = r_mosi;
    assign o_spi_cs_n    = r_cs_n;
endmodule

// File: tb/tb_spi_master_24.sv
// tb_spi_master_24
//   Bench for spi_master_24 (CLK_DIV=4, DATA_WIDTH=24). Transactions come
//   from a table of fixed vectors plus random ones; expectations are
//   derived from the transfer rules (bit order, clamped depth, phase
//   timing) with plain arithmetic. A simple device model returns a chosen
//   MISO word, changing its bit after each SCLK fall.
module tb_spi_master_24;
    localparam int CD = 4;

    typedef struct {
        logic        dir;
        logic [23:0] tx;
        logic [7:0]  depth;
        logic [23:0] miso;
        logic        poke;
        logic [23:0] exp_rx;
        int          exp_sclks;
        int          exp_done;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic spi_miso = 1'b0;
    logic spi_sclk;
    logic spi_mosi;
    logic spi_cs_n;

    int tests = 0;
    int failed = 0;
    int cyc = 0;
    int g_fall_abs;
    int g_rise_abs;
    logic [23:0] model_rx;
    vec_t vecs[$];

    spi_master_24_if #(.DATA_WIDTH(24)) bus ();

    spi_master_24 #(.CLK_DIV(CD), .DATA_WIDTH(24)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .i_spi_miso (spi_miso),
        .o_spi_sclk (spi_sclk),
        .o_spi_mosi (spi_mosi),
        .o_spi_cs_n (spi_cs_n)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint got, input longint exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic int eff_n(input logic [7:0] d);
        return (d > 8'd24) ? 24 : int'(d);
    endfunction

    function automatic logic [23:0] lowmask(input int n);
        logic [31:0] m;
        m = (32'd1 << n) - 32'd1;
        return m[23:0];
    endfunction

    function automatic vec_t mk(input logic dir, input logic [23:0] tx,
                                input logic [7:0] depth, input logic [23:0] miso,
                                input logic poke);
        vec_t v;
        int n;
        n = eff_n(depth);
        v.dir = dir; v.tx = tx; v.depth = depth; v.miso = miso; v.poke = poke;
        v.exp_rx    = dir ? (miso & lowmask(n)) : model_rx;
        v.exp_sclks = n;
        v.exp_done  = 1 + CD * (2 * n + 2);
        model_rx    = v.exp_rx;
        return v;
    endfunction

    // Runs one transaction; with chain=1 it returns right at the done
    // sample so the caller can issue the next start in the done cycle.
    task automatic run_vec(input vec_t v, input bit chain);
        int n, rises, falls, cs_fall, cs_rise, done_at, first_rise, limit;
        logic [23:0] got;
        logic prev_sclk;
        n = eff_n(v.depth);
        for (int w = 0; w < 500 && bus.o_ready !== 1'b1; w++) begin
            @(posedge clk); #1;
        end
        check("ready_before_start", bus.o_ready, 1);
        bus.i_start = 1'b1; bus.i_dir = v.dir; bus.i_data_tx = v.tx;
        bus.i_data_depth = v.depth;
        spi_miso = v.miso[n-1];
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        bus.i_data_tx = 24'($urandom);
        bus.i_dir = ~v.dir;
        got = '0; rises = 0; falls = 0; prev_sclk = 1'b0;
        cs_fall = -1; cs_rise = -1; done_at = -1; first_rise = -1;
        limit = 1 + CD * (2 * n + 2) + 10;
        for (int cc = 1; cc <= limit; cc++) begin
            @(posedge clk); #1;
            bus.i_start = (v.poke && cc == 20);
            if (spi_sclk && !prev_sclk) begin
                got = {got[22:0], spi_mosi};
                rises++;
                if (first_rise < 0) first_rise = cc;
            end
            if (!spi_sclk && prev_sclk) begin
                falls++;
                if (falls < n) spi_miso = v.miso[n-1-falls];
            end
            prev_sclk = spi_sclk;
            if (!spi_cs_n && cs_fall < 0) begin cs_fall = cc; g_fall_abs = cyc; end
            if (spi_cs_n && cs_fall >= 0 && cs_rise < 0) begin cs_rise = cc; g_rise_abs = cyc; end
            if (bus.o_done === 1'b1) begin
                done_at = cc;
                break;
            end
        end
        bus.i_start = 1'b0;
        check("cs_fall_cycle", cs_fall, 1);
        check("first_sclk_rise", first_rise, 1 + CD);
        check("sclk_count", rises, v.exp_sclks);
        check("mosi_bits", got, v.tx & lowmask(n));
        check("cs_rise_cycle", cs_rise, 1 + CD * (2 * n + 1));
        check("done_cycle", done_at, v.exp_done);
        check("ready_at_done", bus.o_ready, 1);
        check("data_rx", bus.o_data_rx, v.exp_rx);
        if (!chain) begin
            @(posedge clk); #1;
            check("done_one_cycle", bus.o_done, 0);
            check("idle_cs_n", spi_cs_n, 1);
        end
    endtask

    initial begin
        int rise_a, nz_events;
        bus.i_start = 1'b0; bus.i_dir = 1'b0; bus.i_data_tx = '0; bus.i_data_depth = '0;

        // Reset values
        #12;
        check("rst_ready", bus.o_ready, 0);
        check("rst_done", bus.o_done, 0);
        check("rst_data_rx", bus.o_data_rx, 0);
        check("rst_sclk", spi_sclk, 0);
        check("rst_mosi", spi_mosi, 0);
        check("rst_cs_n", spi_cs_n, 1);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("ready_after_release", bus.o_ready, 1);

        // Vector table: fixed cases with hand-derived expectations, then random
        model_rx = '0;
        vecs.push_back('{1'b0, 24'h1F8093, 8'd24, 24'h000000, 1'b0, 24'h000000, 24, 201});
        vecs.push_back('{1'b1, 24'h800000, 8'd24, 24'hA5C3F0, 1'b0, 24'hA5C3F0, 24, 201});
        vecs.push_back('{1'b0, 24'hFFFF3C, 8'd8,  24'h000000, 1'b0, 24'hA5C3F0, 8,  73});
        vecs.push_back('{1'b0, 24'h123456, 8'd12, 24'h000000, 1'b1, 24'hA5C3F0, 12, 105});
        vecs.push_back('{1'b1, 24'hABCDEF, 8'd30, 24'h5A5A5A, 1'b0, 24'h5A5A5A, 24, 201});
        vecs.push_back('{1'b1, 24'h000001, 8'd1,  24'h000001, 1'b0, 24'h000001, 1,  17});
        model_rx = 24'h000001;
        for (int i = 0; i < 8; i++) begin
            vecs.push_back(mk(1'($urandom), 24'($urandom), 8'($urandom_range(1, 30)),
                              24'($urandom), 1'b0));
        end
        foreach (vecs[i]) run_vec(vecs[i], 1'b0);

        // depth 0 while idle: ignored
        bus.i_start = 1'b1; bus.i_data_depth = 8'd0; bus.i_data_tx = 24'hFFFFFF;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        nz_events = 0;
        for (int cc = 0; cc < 30; cc++) begin
            @(posedge clk); #1;
            if (!spi_cs_n || spi_sclk || bus.o_done) nz_events++;
        end
        check("depth0_no_activity", nz_events, 0);
        check("depth0_ready", bus.o_ready, 1);
        check("depth0_rx_kept", bus.o_data_rx, model_rx);

        // Back-to-back: second start issued in the done cycle, accepted at
        // the following edge; cs_n high from rise to the next fall is the
        // CD-cycle GAP plus the done cycle plus the accept cycle.
        run_vec(mk(1'b1, 24'hC0FFEE, 8'd16, 24'h00BEEF, 1'b0), 1'b1);
        rise_a = g_rise_abs;
        run_vec(mk(1'b0, 24'h1F8093, 8'd24, 24'h000000, 1'b0), 1'b0);
        check("b2b_cs_gap", g_fall_abs - rise_a, CD + 2);
        check("b2b_gap_min", (g_fall_abs - rise_a) >= CD, 1);

        // Reset at bit 10 of a 24-bit write aborts asynchronously
        check("rx_nonzero_before_abort", bus.o_data_rx != 24'h0, 1);
        bus.i_start = 1'b1; bus.i_dir = 1'b0; bus.i_data_tx = 24'hFFFFFF; bus.i_data_depth = 8'd24;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        begin
            int rises;
            logic prev;
            rises = 0; prev = 1'b0;
            for (int cc = 0; cc < 500 && rises < 10; cc++) begin
                @(posedge clk); #1;
                if (spi_sclk && !prev) rises++;
                prev = spi_sclk;
            end
            check("abort_reached_bit10", rises, 10);
        end
        #2 rst = 1'b1;
        #1;
        check("abort_cs_n", spi_cs_n, 1);
        check("abort_sclk", spi_sclk, 0);
        check("abort_data_rx", bus.o_data_rx, 0);
        check("abort_done", bus.o_done, 0);
        @(posedge clk); @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("abort_ready_after_release", bus.o_ready, 1);
        model_rx = '0;
        run_vec(mk(1'b0, 24'h5AA5C3, 8'd24, 24'h000000, 1'b0), 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
